// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns note events to voice slots using LRU ages,
// with retrigger, idle/releasing reuse and oldest-active stealing.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7,
    parameter int VEL_W      = 7
) (
    input  logic                         IN_CLOCK,
    input  logic                         IN_RESET,
    input  logic                         IN_EVENT_VALID,
    input  logic                         IN_EVENT_NOTE_ON,
    input  logic [NOTE_W-1:0]            IN_NOTE,
    input  logic [VEL_W-1:0]             IN_VELOCITY,
    output logic                         OUT_EVENT_READY,
    input  logic [NUM_VOICES-1:0]        IN_RELEASE_DONE,
    output logic [NUM_VOICES*NOTE_W-1:0] OUT_VOICE_NOTE,
    output logic [NUM_VOICES*VEL_W-1:0]  OUT_VOICE_VEL,
    output logic [NUM_VOICES-1:0]        OUT_VOICE_GATE,
    output logic [NUM_VOICES-1:0]        OUT_VOICE_BUSY,
    output logic [NUM_VOICES-1:0]        OUT_TRIGGER,
    output logic                         OUT_STEAL
);
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam int AGE_W = IDX_W;

    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    localparam logic [1:0] V_IDLE   = 2'd0;
    localparam logic [1:0] V_ACTIVE = 2'd1;
    localparam logic [1:0] V_REL    = 2'd2;

    localparam logic [2:0] ACT_NONE   = 3'd0;
    localparam logic [2:0] ACT_OFF    = 3'd1;
    localparam logic [2:0] ACT_RETRIG = 3'd2;
    localparam logic [2:0] ACT_ALLOC  = 3'd3;
    localparam logic [2:0] ACT_STEAL  = 3'd4;

    logic [1:0]            r_fsm;
    logic                  r_ev_on;
    logic [NOTE_W-1:0]     r_ev_note;
    logic [VEL_W-1:0]      r_ev_vel;
    logic [2:0]            r_act;
    logic [IDX_W-1:0]      r_tgt;
    logic [NUM_VOICES-1:0] r_trig;
    logic                  r_steal;

    logic [1:0]            r_vstate [NUM_VOICES];
    logic [NOTE_W-1:0]     r_note   [NUM_VOICES];
    logic [VEL_W-1:0]      r_vel    [NUM_VOICES];
    logic [AGE_W-1:0]      r_age    [NUM_VOICES];

    logic                  w_hit, w_idle, w_rel;
    logic [IDX_W-1:0]      w_hit_idx, w_idle_idx, w_rel_idx, w_old_idx;
    logic [AGE_W-1:0]      w_rel_age, w_old_age;
    logic [2:0]            w_act;
    logic [IDX_W-1:0]      w_tgt;

    // Target selection from the latched event and the current voice snapshot
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_idle     = 1'b0;
        w_idle_idx = '0;
        w_rel      = 1'b0;
        w_rel_idx  = '0;
        w_rel_age  = '0;
        w_old_idx  = '0;
        w_old_age  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_vstate[i] == V_ACTIVE && r_note[i] == r_ev_note) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (r_vstate[i] == V_IDLE && !w_idle) begin
                w_idle     = 1'b1;
                w_idle_idx = IDX_W'(i);
            end
            if (r_vstate[i] == V_REL && (!w_rel || r_age[i] > w_rel_age)) begin
                w_rel     = 1'b1;
                w_rel_idx = IDX_W'(i);
                w_rel_age = r_age[i];
            end
            // Only reached when every voice is ACTIVE, so the overall oldest is the victim
            if (r_age[i] >= w_old_age) begin
                w_old_idx = IDX_W'(i);
                w_old_age = r_age[i];
            end
        end

        w_act = ACT_NONE;
        w_tgt = w_hit_idx;
        if (r_ev_on) begin
            if (w_hit) begin
                w_act = ACT_RETRIG;
            end else if (w_idle) begin
                w_act = ACT_ALLOC;
                w_tgt = w_idle_idx;
            end else if (w_rel) begin
                w_act = ACT_ALLOC;
                w_tgt = w_rel_idx;
            end else begin
                w_act = ACT_STEAL;
                w_tgt = w_old_idx;
            end
        end else if (w_hit) begin
            w_act = ACT_OFF;
        end
    end

    always_ff @(posedge IN_CLOCK) begin
        if (IN_RESET) begin
            r_fsm     <= ST_WAIT;
            r_ev_on   <= 1'b0;
            r_ev_note <= '0;
            r_ev_vel  <= '0;
            r_act     <= ACT_NONE;
            r_tgt     <= '0;
            r_trig    <= '0;
            r_steal   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_vstate[i] <= V_IDLE;
                r_note[i]   <= '0;
                r_vel[i]    <= '0;
                r_age[i]    <= AGE_W'(i);
            end
        end else begin
            r_trig  <= '0;
            r_steal <= 1'b0;
            // Release completion first; a same-cycle APPLY write below overrides it
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IN_RELEASE_DONE[i] && r_vstate[i] == V_REL)
                    r_vstate[i] <= V_IDLE;
            end
            case (r_fsm)
                ST_WAIT: begin
                    if (IN_EVENT_VALID) begin
                        r_ev_on   <= IN_EVENT_NOTE_ON && (IN_VELOCITY != '0);
                        r_ev_note <= IN_NOTE;
                        r_ev_vel  <= IN_VELOCITY;
                        r_fsm     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_act <= w_act;
                    r_tgt <= w_tgt;
                    r_fsm <= ST_APPLY;
                end
                ST_APPLY: begin
                    r_fsm <= ST_WAIT;
                    case (r_act)
                        ACT_OFF: r_vstate[r_tgt] <= V_REL;
                        ACT_RETRIG, ACT_ALLOC, ACT_STEAL: begin
                            r_vstate[r_tgt] <= V_ACTIVE;
                            r_note[r_tgt]   <= r_ev_note;
                            r_vel[r_tgt]    <= r_ev_vel;
                            r_trig[r_tgt]   <= 1'b1;
                            r_steal         <= (r_act == ACT_STEAL);
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (IDX_W'(i) == r_tgt)
                                    r_age[i] <= '0;
                                else if (r_age[i] < r_age[r_tgt])
                                    r_age[i] <= r_age[i] + AGE_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
                default: r_fsm <= ST_WAIT;
            endcase
        end
    end

    assign OUT_EVENT_READY = (r_fsm == ST_WAIT);
    assign OUT_TRIGGER     = r_trig;
    assign OUT_STEAL       = r_steal;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        assign OUT_VOICE_NOTE[g*NOTE_W +: NOTE_W] = r_note[g];
        assign OUT_VOICE_VEL[g*VEL_W +: VEL_W]    = r_vel[g];
        assign OUT_VOICE_GATE[g]                  = (r_vstate[g] == V_ACTIVE);
        assign OUT_VOICE_BUSY[g]                  = (r_vstate[g] != V_IDLE);
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler between the MIDI parser and the per-voice sample generator / envelope chain.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of NUM_VOICES voice slots.
- Drives each voice's note index, velocity, gate and a one-cycle retrigger pulse.
- Steals a voice when all slots are busy; recovers releasing voices when their envelope reports completion.

Parameters:
- NUM_VOICES, 4: number of voice slots, 2..8.
- NOTE_W, 7: note/frequency-index width.
- VEL_W, 7: velocity width.

Ports:
- IN_CLOCK  input  1  system clock; all logic is on its rising edge.
- IN_RESET  input  1  synchronous, active-high reset.
- IN_EVENT_VALID  input  1  event present on the IN_EVENT_* / IN_NOTE / IN_VELOCITY inputs.
- IN_EVENT_NOTE_ON  input  1  1 = note-on, 0 = note-off.
- IN_NOTE  input  NOTE_W  MIDI note / frequency-table index.
- IN_VELOCITY  input  VEL_W  velocity; ignored for note-off.
- OUT_EVENT_READY  output  1  allocator can accept an event.
- IN_RELEASE_DONE  input  NUM_VOICES  per-voice pulse: envelope release finished.
- OUT_VOICE_NOTE  output  NUM_VOICES*NOTE_W  packed note per voice; voice i occupies bits [i*NOTE_W +: NOTE_W].
- OUT_VOICE_VEL  output  NUM_VOICES*VEL_W  packed velocity per voice.
- OUT_VOICE_GATE  output  NUM_VOICES  voice key held.
- OUT_VOICE_BUSY  output  NUM_VOICES  voice ACTIVE or RELEASING.
- OUT_TRIGGER  output  NUM_VOICES  one-cycle pulse: voice (re)started, envelope restarts attack.
- OUT_STEAL  output  1  one-cycle pulse, coincident with OUT_TRIGGER, when an ACTIVE voice was stolen.

Behaviour:
- Reset (sync, IN_RESET=1 at a rising edge):
  - All voices IDLE; NOTE=0, VEL=0, GATE=0, BUSY=0, TRIGGER=0, STEAL=0.
  - Age rank of voice i = i.
  - FSM to ST_WAIT; OUT_EVENT_READY=1 from the first edge after reset.
  - Reset asserted mid-event discards the latched event.
- Per-voice state is IDLE / ACTIVE / RELEASING.
  - GATE=1 only when ACTIVE.
  - BUSY=1 when ACTIVE or RELEASING.
- Age ranks are an LRU permutation of 0..NUM_VOICES-1, where higher means older.
  - On any allocation or retrigger of voice v with rank r: voice v gets rank 0; every voice with rank < r is incremented; all others are unchanged.
  - Ranks always remain a permutation.
- Main FSM:
  - ST_WAIT: READY=1. A handshake (VALID & READY at an edge) latches the event and moves to ST_SCAN.
  - ST_SCAN: READY=0. Computes the target voice and action from the latched event and voice state; registers both; moves to ST_APPLY.
  - ST_APPLY: READY=0. Updates voice registers and pulses TRIGGER/STEAL; moves to ST_WAIT.
  - Timing: for a handshake at edge k, outputs change at edge k+2 and READY is high again after edge k+2. Maximum rate is one event per 3 cycles.
- Note-on with IN_VELOCITY=0 is treated exactly as note-off.
- Note-on target selection, first match wins:
  1. An ACTIVE voice with the same note: retrigger. Update VEL, pulse TRIGGER, no STEAL.
  2. The lowest-index IDLE voice.
  3. The RELEASING voice with the highest age rank.
  4. The ACTIVE voice with the highest age rank: steal, pulse STEAL.
  - For cases 2–4: set NOTE and VEL, state ACTIVE, pulse TRIGGER[v].
- Note-off:
  - The ACTIVE voice with a matching note goes to RELEASING (GATE=0); NOTE and VEL are held. Ages are unchanged; no pulses.
  - At most one voice matches, because rule 1 prevents duplicate active notes.
  - No match: the event is consumed and nothing changes.
- IN_RELEASE_DONE[i]:
  - Evaluated every cycle, independent of the FSM.
  - Moves voice i from RELEASING to IDLE.
  - Ignored if voice i is IDLE or ACTIVE.
- Simultaneous events:
  - If ST_APPLY writes voice v in the same cycle as RELEASE_DONE[v], the APPLY write wins and the voice ends ACTIVE.
  - Voice-state snapshots taken in ST_SCAN may be stale by one cycle. If the chosen RELEASING voice becomes IDLE before APPLY, the allocation still proceeds to that voice and is not a steal.
- TRIGGER and STEAL are zero in every cycle other than ST_APPLY with a note-on.

Test Plan:
1. Reset; note-on 60/vel 100 handshake at edge k → at edge k+2 voice0 NOTE=60, VEL=100, GATE=0001, TRIGGER=0001 for one cycle; READY low for exactly 2 cycles.
2. Note-ons 60, 62, 64, 65, then 67 → voices 0–3 fill in order; the fifth steals voice0 (oldest): NOTE0=67, TRIGGER=0001, STEAL=1; ranks become v0=0, v1=3, v2=2, v3=1.
3. From the state after scenario 2: note-off 62 → GATE=1101, BUSY=1111; then note-on 70 → allocated to voice1 (the RELEASING voice beats stealing), STEAL=0.
4. Note-on 64 vel 20 while voice2 holds 64 → retrigger voice2, VEL2=20, TRIGGER=0100, no other voice changes.
5. Note-on 50 vel 0 with 50 active on voice3 → voice3 RELEASING; note-off 99 (not playing) → no output change, READY returns after 2 cycles; RELEASE_DONE=1000 → BUSY3=0.
6. RELEASE_DONE[v] coincident with ST_APPLY to v → voice ACTIVE. Separately, IN_RESET asserted during ST_SCAN → all outputs are at reset values next cycle, READY=1, and the latched event is dropped.
